div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  request pulse; sampled on the rising edge only while busy=0.
REQ-005 Port: op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
REQ-006 Port: dividend  input  32  rs1 operand; sampled with start.
REQ-007 Port: divisor  input  32  rs2 operand; sampled with start.
REQ-008 Port: busy  output  1  operation in progress; high from the cycle after start through the done cycle.
REQ-009 Port: done  output  1  one-cycle pulse; result is valid in this cycle.
REQ-010 Port: result  output  32  quotient or remainder; held from done until the next accepted start.

Function
REQ-011 The block SHALL implement three states: IDLE, CALC and FIN.
- IDLE to CALC on an accepted start.
- CALC to FIN after 32 iterations.
- FIN to IDLE after one cycle.
REQ-012 The block SHALL register op, |dividend| and |divisor| when start is accepted.
- Signed ops (DIV, REM) use two's-complement magnitudes.
- Unsigned ops (DIVU, REMU) use the raw values.
REQ-013 CALC SHALL perform one restoring shift-subtract iteration per cycle on a 33-bit partial remainder, driven by a 5-bit down-counter from 31 to 0.
REQ-014 Normal latency: start high in cycle 0 gives busy=1 in cycles 1..33, done=1 in cycle 33 only, and busy=0 from cycle 34.
REQ-015 Signed sign fix-up, applied in FIN:
- The quotient is negated when the operand signs differ.
- The remainder takes the sign of the dividend.
REQ-016 Divisor==0 is a fast path: done and busy are asserted in cycle 1 only.
- Quotient = 0xFFFFFFFF.
- Remainder = dividend, unmodified.
REQ-017 Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF) is a fast path, finishing in cycle 1.
- Quotient = 0x80000000.
- Remainder = 0.
REQ-018 Divide-by-zero SHALL take precedence over overflow; there are no exceptions and no other flags.
REQ-019 result SHALL be the quotient for op 00/01 and the remainder for op 10/11.
REQ-020 start while busy=1 (including the done cycle) SHALL be ignored; inputs SHALL NOT be re-sampled.
REQ-021 start in the first cycle after done SHALL be accepted (back-to-back issue).
REQ-022 Input changes while busy SHALL NOT affect the in-flight result.
REQ-023 All arithmetic SHALL be modulo 2^32; magnitude 0x80000000 is treated as unsigned 2^31.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, result=0, counter=0 and clear internal registers, independent of clk.
REQ-025 Reset asserted during CALC or FIN SHALL abort the operation; no done pulse follows.
REQ-026 After rst_n rises, the first start SHALL be accepted on the next rising edge.

Verification
REQ-027 DIVU 100/7, start cycle 0 -> done only in cycle 33, result=14; REMU same operands -> result=2.
REQ-028 DIV 0xFFFFFFF9(-7)/2 -> result=0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1); DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-029 DIVU 5/0 -> done in cycle 1, result=0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1; REM -> 0.
REQ-030 DIVU 1000/10 with a second start (DIVU 9/3) in cycle 10 -> result=100 in cycle 33; second start dropped; busy=0 in cycle 34.
REQ-031 rst_n pulsed low in cycle 12 of DIVU 0xFFFFFFFF/1 -> busy, done and result are 0 within the same cycle; no done afterwards; a new DIVU 9/3 then returns 3 after 33 cycles.
REQ-032 Back-to-back: DIVU 0xFFFFFFFF/0x10000 then start in the cycle after done with REMU 0xFFFFFFFF/0x10000 -> results 0xFFFF then 0xFFFF, done pulses 34 cycles apart.

Source files
------------

// File: rtl/div_unit.sv
// Purpose : 32-bit RISC-V style divider (DIV/DIVU/REM/REMU), restoring shift-subtract, one bit per cycle.
// Latency : 33 cycles from accepted start to done; 1 cycle for divide-by-zero and signed overflow.
// Backpr. : no queueing; start is accepted only while busy=0, otherwise it is dropped.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - request pulse, sampled only while busy=0
//   op       - 00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//   dividend - rs1 operand (sampled with start)
//   divisor  - rs2 operand (sampled with start)
//   busy     - high from the cycle after an accepted start through the done cycle
//   done     - one-cycle pulse, result valid in this cycle
//   result   - quotient or remainder, held from done until the next accepted start
module div_unit #(
    parameter int XLEN = 32   // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    logic [4:0]      r_cnt;
    logic [XLEN:0]   r_rem;      // 33-bit partial remainder
    logic [XLEN-1:0] r_quo;      // dividend shifts out of the top, quotient bits shift in
    logic [XLEN-1:0] r_dvs;      // divisor magnitude
    logic            r_sel_rem;  // 1: result is remainder
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_fast;     // result already final, skip sign fix-up
    logic [XLEN-1:0] r_result;

    // Operand decode at accept time
    logic            w_signed;
    logic [XLEN-1:0] w_dvd_abs;
    logic [XLEN-1:0] w_dvs_abs;
    logic            w_div_zero;
    logic            w_overflow;

    assign w_signed   = ~op[0];
    // Two's-complement negation of 0x80000000 yields 0x80000000, read as unsigned 2^31.
    assign w_dvd_abs  = (w_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
    assign w_dvs_abs  = (w_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
    assign w_div_zero = (divisor == '0);
    assign w_overflow = w_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

    // One restoring iteration
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic [XLEN:0]   w_rem_next;
    logic            w_q_bit;

    assign w_shift    = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_q_bit    = ~w_diff[XLEN];   // no borrow: subtraction fits
    assign w_rem_next = w_q_bit ? w_diff : w_shift;

    // Sign fix-up, evaluated while in FIN
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_fixed;

    assign w_q_fix = (r_fast || !r_neg_q) ? r_quo : (~r_quo + 1'b1);
    assign w_r_fix = (r_fast || !r_neg_r) ? r_rem[XLEN-1:0] : (~r_rem[XLEN-1:0] + 1'b1);
    assign w_fixed = r_sel_rem ? w_r_fix : w_q_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_fast    <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel_rem <= op[1];
                        r_neg_q   <= w_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        r_neg_r   <= w_signed & dividend[XLEN-1];
                        r_dvs     <= w_dvs_abs;
                        r_cnt     <= 5'd31;
                        // Divide-by-zero is checked first so it wins over overflow.
                        if (w_div_zero) begin
                            r_fast  <= 1'b1;
                            r_quo   <= '1;
                            r_rem   <= {1'b0, dividend};
                            r_state <= S_FIN;
                        end else if (w_overflow) begin
                            r_fast  <= 1'b1;
                            r_quo   <= {1'b1, {(XLEN-1){1'b0}}};
                            r_rem   <= '0;
                            r_state <= S_FIN;
                        end else begin
                            r_fast  <= 1'b0;
                            r_quo   <= w_dvd_abs;
                            r_rem   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[XLEN-2:0], w_q_bit};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_result <= w_fixed;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FIN);
    // In FIN the fixed-up value is shown directly; it is captured into r_result for holding.
    assign result = (r_state == S_FIN) ? w_fixed : r_result;

endmodule
